// File: rtl/piezo_tone_detector_pkg.sv
// Shared definitions for the piezo tone generator / detector pair.
package piezo_tone_detector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRST   = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } tone_state_t;

    localparam int DEF_CNT_W   = 20;
    localparam int DEF_TIMEOUT = 1000000;

endpackage

// File: rtl/piezo_tone_detector_edge_sync.sv
// Brings the asynchronous tone into the CLK domain and flags either transition.
module tone_edge_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic TONE_IN,
    output logic EDGE
);

    logic sync1, sync2, prev;

    // All three flops reset to the same value so reset release is never an edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= TONE_IN;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign EDGE = sync2 ^ prev;

endmodule

// File: rtl/piezo_tone_detector.sv
// Recovers the generator LIMIT value from the half-period of a piezo square wave
// and reports lock once two consecutive half-periods agree within TOL.
module piezo_tone_detector
    import piezo_tone_detector_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TOL     = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TONE_IN,
    output logic [CNT_W-1:0] LIMIT_OUT,
    output logic             VALID,
    output logic             LOCK_P,
    output logic             LOST_P
);

    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOLV = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             edge_p;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h0_q, h0_d;
    logic [CNT_W-1:0] limit_d;
    logic [CNT_W-1:0] diff;
    logic             in_tol, tmo_hit;
    logic             valid_d, lock_d, lost_d;
    tone_state_t      state_q, state_d;

    tone_edge_sync u_sync (
        .CLK     (CLK),
        .RESET   (RESET),
        .TONE_IN (TONE_IN),
        .EDGE    (edge_p)
    );

    // Clocks since the last edge; the value seen on an edge cycle is H.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (edge_p)
            cnt <= ONE;
        else if (cnt != TMO)
            cnt <= cnt + ONE;
    end

    assign diff    = (cnt >= h0_q) ? (cnt - h0_q) : (h0_q - cnt);
    assign in_tol  = (diff <= TOLV);
    assign tmo_hit = !edge_p && (cnt == TMO);

    always_comb begin
        state_d = state_q;
        h0_d    = h0_q;
        limit_d = LIMIT_OUT;
        valid_d = VALID;
        lock_d  = 1'b0;
        lost_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_p)
                    state_d = FIRST;
            end
            FIRST: begin
                if (edge_p) begin
                    h0_d    = cnt;
                    state_d = MEASURE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            MEASURE: begin
                if (edge_p) begin
                    if (in_tol) begin
                        state_d = LOCKED;
                        limit_d = cnt - ONE;
                        valid_d = 1'b1;
                        lock_d  = 1'b1;
                    end else begin
                        h0_d = cnt;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            LOCKED: begin
                if (edge_p) begin
                    h0_d = cnt;
                    if (in_tol) begin
                        limit_d = cnt - ONE;
                    end else begin
                        state_d = MEASURE;
                        valid_d = 1'b0;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    lost_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            h0_q      <= '0;
            LIMIT_OUT <= '0;
            VALID     <= 1'b0;
            LOCK_P    <= 1'b0;
            LOST_P    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h0_q      <= h0_d;
            LIMIT_OUT <= limit_d;
            VALID     <= valid_d;
            LOCK_P    <= lock_d;
            LOST_P    <= lost_d;
        end
    end

endmodule

// File: tb/tb_piezo_tone_detector.sv
// Bench for piezo_tone_detector: edge table plus hand sequences, lock/lost pulses scoreboarded.
module tb_piezo_tone_detector;

    localparam int CW = 20;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          TONE_IN = 1'b0;
    logic [CW-1:0] lim0, lim1;
    logic          v0, v1, lk0, lk1, ls0, ls1;

    always #5 CLK = ~CLK;

    // dut0: strict lock, short timeout; dut1: one-clock tolerance.
    piezo_tone_detector #(.CNT_W(CW), .TIMEOUT(20), .TOL(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .TONE_IN(TONE_IN),
        .LIMIT_OUT(lim0), .VALID(v0), .LOCK_P(lk0), .LOST_P(ls0)
    );

    piezo_tone_detector #(.CNT_W(CW), .TIMEOUT(40), .TOL(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .TONE_IN(TONE_IN),
        .LIMIT_OUT(lim1), .VALID(v1), .LOCK_P(lk1), .LOST_P(ls1)
    );

    int checks   = 0;
    int failures = 0;
    int since    = 100;
    int lock1    = 0;
    int lost1    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_lost;
        logic [31:0] limit;
    } ev_t;

    ev_t evq[$];
    ev_t mon_e;

    task automatic push_ev(input logic lost, input int lim);
        ev_t e;
        e.is_lost = lost;
        e.limit   = lim;
        evq.push_back(e);
    endtask

    // dut0 pulses are popped against the expected events queued by the stimulus.
    always @(negedge CLK) begin
        if (!RESET && (lk0 || ls0)) begin
            if (evq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: lock=%0d lost=%0d expected none", lk0, ls0);
            end else begin
                mon_e = evq.pop_front();
                chk("ev_kind_lost", {31'd0, ls0}, {31'd0, mon_e.is_lost});
                chk("ev_limit", {12'd0, lim0}, mon_e.limit);
                chk("ev_valid", {31'd0, v0}, {31'd0, !mon_e.is_lost});
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            if (lk1) lock1++;
            if (ls1) lost1++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        since++;
    endtask

    task automatic toggle();
        TONE_IN = ~TONE_IN;
        since   = 0;
    endtask

    typedef struct {
        int h;
        int valid;
        int limit;
        int ev;
        int sel;
    } row_t;

    row_t rows[20];

    // Edge spaced h clocks after the previous one, then check once it is processed.
    task automatic apply_row(input int i);
        while (since < rows[i].h) tick();
        toggle();
        if (rows[i].ev == 1) push_ev(1'b0, rows[i].limit);
        repeat (3) tick();
        if (rows[i].sel == 0) begin
            chk($sformatf("row%0d_valid", i), {31'd0, v0}, rows[i].valid);
            chk($sformatf("row%0d_limit", i), {12'd0, lim0}, rows[i].limit);
        end else begin
            chk($sformatf("row%0d_valid1", i), {31'd0, v1}, rows[i].valid);
            chk($sformatf("row%0d_limit1", i), {12'd0, lim1}, rows[i].limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lb, sb;
        rows[0]  = '{10, 0, 0,  0, 0};
        rows[1]  = '{10, 0, 0,  0, 0};
        rows[2]  = '{10, 1, 9,  1, 0};
        rows[3]  = '{10, 1, 9,  0, 0};
        rows[4]  = '{5,  0, 9,  0, 0};
        rows[5]  = '{5,  1, 4,  1, 0};
        rows[6]  = '{5,  1, 4,  0, 0};
        rows[7]  = '{20, 0, 4,  0, 0};
        rows[8]  = '{20, 1, 19, 1, 0};
        rows[9]  = '{20, 1, 19, 0, 0};
        rows[10] = '{10, 0, 19, 0, 0};
        rows[11] = '{10, 0, 19, 0, 0};
        rows[12] = '{10, 1, 9,  1, 0};
        rows[13] = '{10, 0, 0,  0, 1};
        rows[14] = '{10, 0, 0,  0, 1};
        rows[15] = '{11, 1, 10, 0, 1};
        rows[16] = '{10, 1, 9,  0, 1};
        rows[17] = '{11, 1, 10, 0, 1};
        rows[18] = '{10, 1, 9,  0, 1};
        rows[19] = '{11, 1, 10, 0, 1};

        repeat (3) tick();
        chk("rst_valid",  {31'd0, v0},  0);
        chk("rst_limit",  {12'd0, lim0}, 0);
        chk("rst_lock_p", {31'd0, lk0}, 0);
        chk("rst_lost_p", {31'd0, ls0}, 0);
        chk("rst_valid1", {31'd0, v1},  0);
        RESET = 1'b0;

        // Lock at H=10, retune to H=5, then H=20 with edges landing on CNT==TIMEOUT.
        for (int i = 0; i <= 9; i++) apply_row(i);

        // Tone stops: lost exactly when CNT sits at TIMEOUT without an edge.
        push_ev(1'b1, 19);
        while (since < 22) tick();
        chk("tmo_valid_before", {31'd0, v0}, 1);
        tick();
        chk("tmo_valid_after", {31'd0, v0}, 0);
        chk("tmo_limit_hold", {12'd0, lim0}, 19);

        // Back in IDLE: a full three-edge sequence is needed again.
        for (int i = 10; i <= 12; i++) apply_row(i);

        // H=1 (LIMIT=0): one edge at H=3 unlocks, then two H=1 edges relock.
        push_ev(1'b0, 0);
        repeat (6) begin
            toggle();
            tick();
        end
        tick();
        tick();
        chk("h1_valid", {31'd0, v0}, 1);
        chk("h1_limit", {12'd0, lim0}, 0);

        // Reset mid-lock drops everything at once, with no lost pulse.
        RESET = 1'b1;
        #1;
        chk("midrst_valid",  {31'd0, v0}, 0);
        chk("midrst_limit",  {12'd0, lim0}, 0);
        chk("midrst_lock_p", {31'd0, lk0}, 0);
        chk("midrst_lost_p", {31'd0, ls0}, 0);
        TONE_IN = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        repeat (5) tick();

        // Three H=1 edges relock; release itself must not count as an edge.
        push_ev(1'b0, 0);
        repeat (3) begin
            toggle();
            tick();
        end
        tick();
        chk("relock_valid_edge2", {31'd0, v0}, 0);
        tick();
        chk("relock_valid_edge3", {31'd0, v0}, 1);
        chk("relock_limit", {12'd0, lim0}, 0);
        tick();

        RESET = 1'b1;
        tick();
        TONE_IN = 1'b0;
        tick();
        RESET = 1'b0;
        since = 100;
        lb = lock1;
        sb = lost1;

        // Alternating H=10/11 under TOL=1 stays locked (dut1).
        for (int i = 13; i <= 19; i++) apply_row(i);
        chk("tol_lock_count", lock1 - lb, 1);
        chk("tol_lost_count", lost1 - sb, 0);
        chk("tol_dut0_valid", {31'd0, v0}, 0);

        repeat (50) tick();
        chk("tol_lost_after_stop", lost1 - sb, 1);
        chk("tol_valid_after_stop", {31'd0, v1}, 0);
        chk("scoreboard_empty", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
